// File: rtl/fft_frame_buffer_mc.sv
// Decimating multi-channel sliding-window buffer that streams oldest-to-newest frames to an FFT.
// First beat 2 cycles after a request is accepted; while fft_ready is low the current beat holds.
module fft_frame_buffer_mc #(
  parameter int DATA_W = 22,
  parameter int N_LOG2 = 10,
  parameter int DECIM  = 12,
  parameter int HOP    = 1,
  parameter int NUM_CH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH*DATA_W-1:0]   sample_in,
  input  logic                       sample_valid,
  input  logic                       fft_ready,
  output logic [NUM_CH*2*DATA_W-1:0] fft_din,
  output logic                       fft_valid,
  output logic                       fft_sync,
  output logic                       fft_last,
  output logic                       primed,
  output logic                       busy,
  output logic                       overrun,
  output logic [15:0]                frame_count
);
  localparam int N     = 1 << N_LOG2;
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int HOP_W = N_LOG2 + 1;
  localparam int SW    = NUM_CH * DATA_W;

  typedef enum logic [1:0] {S_FILL, S_IDLE, S_LOAD, S_STREAM} state_t;
  state_t state, state_nxt;

  logic [DEC_W-1:0]  dec_cnt;
  logic [N_LOG2-1:0] wr_ptr, wr_ptr_nxt, fill_cnt, start, beat_idx, wr_off, rd_addr;
  logic [HOP_W-1:0]  hop_cnt, hop_inc;
  logic              dec_hit, wr_en, fill_req, hop_req, req, pending, accept;
  logic              xfer, last_beat, last_xfer, rd_en;
  logic [SW-1:0]     mem [N];
  logic [SW-1:0]     rd_data;

  assign dec_hit    = (dec_cnt == DEC_W'(DECIM - 1));
  assign wr_en      = sample_valid && dec_hit;
  assign wr_ptr_nxt = wr_en ? wr_ptr + 1'b1 : wr_ptr;
  assign fill_req   = wr_en && !primed && (fill_cnt == N_LOG2'(N - 1));
  assign hop_inc    = hop_cnt + 1'b1;
  assign hop_req    = wr_en && primed && (hop_inc == HOP_W'(HOP));
  assign req        = fill_req || hop_req;
  // FILL accepts the priming request directly so the first frame has the same latency as later ones
  assign accept     = ((state == S_FILL) || (state == S_IDLE)) && (req || pending);
  assign last_beat  = (beat_idx == N_LOG2'(N - 1));
  assign xfer       = (state == S_STREAM) && fft_ready;
  assign last_xfer  = xfer && last_beat;
  assign rd_en      = (state == S_LOAD) || (xfer && !last_beat);
  assign rd_addr    = (state == S_LOAD) ? start : start + beat_idx + 1'b1;
  assign wr_off     = wr_ptr - start;

  // Decimator, write pointer, fill and hop counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dec_cnt  <= '0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      hop_cnt  <= '0;
      primed   <= 1'b0;
    end else begin
      if (sample_valid) dec_cnt <= dec_hit ? '0 : dec_cnt + 1'b1;
      wr_ptr <= wr_ptr_nxt;
      if (wr_en && !primed) fill_cnt <= fill_cnt + 1'b1;
      if (fill_req) primed <= 1'b1;
      if (hop_req) hop_cnt <= '0;
      else if (wr_en && primed) hop_cnt <= hop_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_in;
  end

  // Read register only advances on a transfer, so a stalled beat holds its data
  always_ff @(posedge clk) begin
    if (!reset_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start       <= '0;
      beat_idx    <= '0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      if (accept) start <= wr_ptr_nxt;
      if (state == S_LOAD) beat_idx <= '0;
      else if (xfer) beat_idx <= beat_idx + 1'b1;
      if (accept) pending <= 1'b0;
      else if (req && !pending) pending <= 1'b1;
      if (req && pending) overrun <= 1'b1;
      // Offsets above beat_idx belong to the active frame but have not been read yet
      if (wr_en && (state == S_STREAM) && (wr_off > beat_idx)) overrun <= 1'b1;
      if (last_xfer) frame_count <= frame_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_FILL;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL, S_IDLE: if (accept) state_nxt = S_LOAD;
      S_LOAD:         state_nxt = S_STREAM;
      S_STREAM:       if (last_xfer) state_nxt = S_IDLE;
      default:        state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    fft_valid = (state == S_STREAM);
    fft_sync  = (state == S_STREAM) && (beat_idx == '0);
    fft_last  = (state == S_STREAM) && last_beat;
    busy      = (state == S_LOAD) || (state == S_STREAM);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    assign fft_din[c*2*DATA_W +: 2*DATA_W] = {rd_data[c*DATA_W +: DATA_W], {DATA_W{1'b0}}};
  end

endmodule

// File: tb/tb_fft_frame_buffer_mc.sv
// Directed bench: main instance (N=16, DECIM=12, HOP=4) and a DECIM=1/HOP=1 instance for queue/overrun cases.
module tb_fft_frame_buffer_mc;
  localparam int W   = 22;
  localparam int N   = 16;
  localparam int NCH = 2;
  localparam int OW  = NCH * 2 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [NCH*W-1:0] sample_in;
  logic            m_valid, q_valid, fft_ready;
  logic [OW-1:0]   m_din, q_din;
  logic            m_fv, m_sync, m_last, m_primed, m_busy, m_ovr;
  logic            q_fv, q_sync, q_last, q_primed, q_busy, q_ovr;
  logic [15:0]     m_fc, q_fc;

  logic            sel;
  logic [OW-1:0]   din;
  logic            fv, sync, last;
  assign din  = sel ? q_din  : m_din;
  assign fv   = sel ? q_fv   : m_fv;
  assign sync = sel ? q_sync : m_sync;
  assign last = sel ? q_last : m_last;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_pc, m_val;
  logic m_seen_valid;

  fft_frame_buffer_mc #(.DATA_W(W), .N_LOG2(4), .DECIM(12), .HOP(4), .NUM_CH(NCH)) u_dut (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(m_valid),
    .fft_ready(fft_ready), .fft_din(m_din), .fft_valid(m_fv), .fft_sync(m_sync),
    .fft_last(m_last), .primed(m_primed), .busy(m_busy), .overrun(m_ovr), .frame_count(m_fc));

  fft_frame_buffer_mc #(.DATA_W(W), .N_LOG2(4), .DECIM(1), .HOP(1), .NUM_CH(NCH)) u_q (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(q_valid),
    .fft_ready(fft_ready), .fft_din(q_din), .fft_valid(q_fv), .fft_sync(q_sync),
    .fft_last(q_last), .primed(q_primed), .busy(q_busy), .overrun(q_ovr), .frame_count(q_fc));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Input sample: ch0 = v, ch1 = -v
  function automatic logic [NCH*W-1:0] pk(input int v);
    logic [W-1:0] a, b;
    a = W'(v);
    b = W'(-v);
    return {b, a};
  endfunction

  // Expected FFT word: {real, zero imag} per channel
  function automatic logic [OW-1:0] mk(input int v);
    logic [W-1:0] a, b;
    a = W'(v);
    b = W'(-v);
    return {b, {W{1'b0}}, a, {W{1'b0}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every 12th pulse carries the next ramp value; other pulses carry junk
  task automatic m_burst(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      m_valid   = 1'b1;
      sample_in = (m_pc == 11) ? pk(m_val) : pk(700 + i % 200);
      tick();
      if (m_fv) m_seen_valid = 1'b1;
      if (m_pc == 11) begin
        m_pc = 0;
        m_val++;
      end else begin
        m_pc++;
      end
    end
    m_valid = 1'b0;
  endtask

  task automatic q_burst(input int cnt, input int v0);
    for (int i = 0; i < cnt; i++) begin
      q_valid   = 1'b1;
      sample_in = pk(v0 + i);
      tick();
    end
    q_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!fv && k < 20) begin
      tick();
      k++;
    end
    chk(tag, fv, 1'b1);
  endtask

  task automatic collect_frame(input int base, input bit bp, input string tag);
    int          beats = 0;
    int          cyc = 0;
    logic [63:0] pat;
    pat = 64'hC93A_5E71_B2D4_8F16;
    while (beats < N && cyc < 300) begin
      if (fv) begin
        chk({tag, "_din"}, din, mk(base + beats));
        chk({tag, "_sync"}, sync, (beats == 0));
        chk({tag, "_last"}, last, (beats == N - 1));
        fft_ready = bp ? pat[cyc % 64] : 1'b1;
        if (fft_ready) beats++;
      end
      tick();
      cyc++;
    end
    chk({tag, "_beats"}, beats, N);
    fft_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    reset_n = 1'b0; sample_in = '0; m_valid = 1'b0; q_valid = 1'b0;
    fft_ready = 1'b1; sel = 1'b0; m_pc = 0; m_val = 0; m_seen_valid = 1'b0;
    tick(); tick();
    chk("rst_din", m_din, '0);
    chk("rst_valid", m_fv, 1'b0);
    chk("rst_sync", m_sync, 1'b0);
    chk("rst_last", m_last, 1'b0);
    chk("rst_primed", m_primed, 1'b0);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_overrun", m_ovr, 1'b0);
    chk("rst_fc", m_fc, 16'd0);
    reset_n = 1'b1;
    tick();

    // Fill: primed on pulse 192, first beat two cycles later
    m_burst(191);
    chk("fill_primed_early", m_primed, 1'b0);
    chk("fill_no_frame", m_seen_valid, 1'b0);
    m_burst(1);
    chk("fill_primed", m_primed, 1'b1);
    chk("fill_busy_load", m_busy, 1'b1);
    chk("fill_valid_load", m_fv, 1'b0);
    tick();
    chk("fill_latency", m_fv, 1'b1);
    chk("fill_sync0", m_sync, 1'b1);
    collect_frame(0, 1'b0, "frame1");
    chk("frame1_idle", m_fv, 1'b0);
    chk("frame1_busy", m_busy, 1'b0);
    chk("frame1_fc", m_fc, 16'd1);

    // Hop with address wrap: ch0 4..19
    m_burst(48);
    wait_valid("hop_start");
    collect_frame(4, 1'b0, "hop");
    chk("hop_fc", m_fc, 16'd2);

    // Backpressure: ch0 8..23
    m_burst(48);
    wait_valid("bp_start");
    collect_frame(8, 1'b1, "bp");
    chk("bp_fc", m_fc, 16'd3);
    chk("bp_overrun", m_ovr, 1'b0);

    // Reset at beat 7
    m_burst(48);
    wait_valid("rstf_start");
    repeat (7) tick();
    chk("rstf_beat7", m_din, mk(19));
    reset_n = 1'b0;
    tick();
    chk("rstf_din", m_din, '0);
    chk("rstf_valid", m_fv, 1'b0);
    chk("rstf_sync", m_sync, 1'b0);
    chk("rstf_last", m_last, 1'b0);
    chk("rstf_primed", m_primed, 1'b0);
    chk("rstf_busy", m_busy, 1'b0);
    chk("rstf_overrun", m_ovr, 1'b0);
    chk("rstf_fc", m_fc, 16'd0);
    reset_n = 1'b1;
    m_pc = 0; m_val = 1000; m_seen_valid = 1'b0;
    m_burst(191);
    chk("rstf_no_frame", m_seen_valid, 1'b0);
    chk("rstf_primed_early", m_primed, 1'b0);
    m_burst(1);
    wait_valid("post_rst_start");
    collect_frame(1000, 1'b0, "post_rst");
    chk("post_rst_fc", m_fc, 16'd1);

    // Queued request on the DECIM=1, HOP=1 instance
    sel = 1'b1;
    reset_n = 1'b0;
    tick();
    chk("q_rst_valid", q_fv, 1'b0);
    chk("q_rst_primed", q_primed, 1'b0);
    reset_n = 1'b1;
    q_burst(16, 0);
    chk("q_primed", q_primed, 1'b1);
    wait_valid("q_first");
    repeat (5) tick();
    chk("q_beat5", din, mk(5));
    q_valid = 1'b1;
    sample_in = pk(16);
    tick();
    q_valid = 1'b0;
    chk("q_beat6", din, mk(6));
    k = 0;
    while (!(fv && last) && k < 30) begin
      tick();
      k++;
    end
    chk("q_last_seen", fv && last, 1'b1);
    tick();
    chk("q_gap1", fv, 1'b0);
    tick();
    chk("q_gap2", fv, 1'b0);
    chk("q_gap2_busy", q_busy, 1'b1);
    tick();
    chk("q_next_valid", fv, 1'b1);
    chk("q_next_sync", sync, 1'b1);
    collect_frame(1, 1'b0, "queued");
    chk("q_fc", q_fc, 16'd2);
    chk("q_no_overrun", q_ovr, 1'b0);

    // Overrun: continuous writes with the FFT stalled
    fft_ready = 1'b0;
    q_burst(3, 17);
    chk("ovr_set", q_ovr, 1'b1);
    fft_ready = 1'b1;
    repeat (60) tick();
    chk("ovr_sticky", q_ovr, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
